// File: rtl/mcycle_sequencer_if.sv
// Descriptor, MMU bus and status signals of the M-cycle sequencer.
// master = CPU/MMU environment side, slave = the sequencer itself.
interface mcycle_sequencer_if #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int MAX_MCYCLES = 6
);
  localparam int CW = $clog2(MAX_MCYCLES + 1);

  logic              cyc_valid;
  logic              cyc_ready;
  logic [1:0]        cyc_op;
  logic [ADDR_W-1:0] cyc_addr;
  logic [DATA_W-1:0] cyc_wdata;
  logic              cyc_last;
  logic [ADDR_W-1:0] addr_bus;
  logic [DATA_W-1:0] wdata_out;
  logic [DATA_W-1:0] rdata_in;
  logic              MMU_req_read;
  logic              MMU_req_write;
  logic              mem_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              insn_done;
  logic [CW-1:0]     mcycle_count;
  logic              busy;
  logic              seq_err;

  modport master (
    output cyc_valid, cyc_op, cyc_addr, cyc_wdata, cyc_last, rdata_in, mem_ready,
    input  cyc_ready, addr_bus, wdata_out, MMU_req_read, MMU_req_write,
           rd_data, rd_valid, insn_done, mcycle_count, busy, seq_err
  );

  modport slave (
    input  cyc_valid, cyc_op, cyc_addr, cyc_wdata, cyc_last, rdata_in, mem_ready,
    output cyc_ready, addr_bus, wdata_out, MMU_req_read, MMU_req_write,
           rd_data, rd_valid, insn_done, mcycle_count, busy, seq_err
  );
endinterface

// File: rtl/mcycle_sequencer.sv
// M-cycle / T-phase sequencer driving MMU read/write strobes from micro-cycle descriptors.
// Define MCYCLE_SEQUENCER_WAIT_STATE_EN to let mem_ready stretch READ/WRITE M-cycles.
module mcycle_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int T_PER_M     = 4,
  parameter int MAX_MCYCLES = 6
) (
  input  logic                clk,
  input  logic                reset,
  mcycle_sequencer_if.slave   bus
);
  localparam int CW = $clog2(MAX_MCYCLES + 1);
  localparam int TW = $clog2(T_PER_M);
  localparam logic [TW-1:0] T_LAST = TW'(T_PER_M - 1);
  localparam logic [TW-1:0] T_CAP  = TW'(T_PER_M - 2);
  localparam logic [CW-1:0] C_MAX  = CW'(MAX_MCYCLES - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_e;
  typedef enum logic [1:0] {OP_IDLE, OP_READ, OP_WRITE, OP_INTERNAL} op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [TW-1:0]     t_q, t_d;
  logic              last_q, last_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              insn_done_q, insn_done_d;
  logic              req_rd_q, req_rd_d;
  logic              req_wr_q, req_wr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;
  logic              stall, accept, act_d;

`ifdef MCYCLE_SEQUENCER_WAIT_STATE_EN
  assign stall = (state_q == S_ACTIVE) && (t_q == T_CAP) &&
                 (op_q inside {OP_READ, OP_WRITE}) && !bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign stall = 1'b0;
`endif

  // A stall only ever holds t at T_CAP, so the last phase is always ready.
  assign bus.cyc_ready = (state_q == S_IDLE) || (t_q == T_LAST);
  assign accept        = bus.cyc_valid && bus.cyc_ready;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    t_d       = t_q;
    last_d    = last_q;
    first_d   = first_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    count_d   = count_q;
    err_d     = err_q;

    if (accept) begin
      state_d = S_ACTIVE;
      t_d     = '0;
      op_d    = (op_e'(bus.cyc_op) == OP_IDLE) ? OP_INTERNAL : op_e'(bus.cyc_op);
      addr_d  = bus.cyc_addr;
      wdata_d = bus.cyc_wdata;
      last_d  = bus.cyc_last;
      first_d = bus.cyc_last;
      // first_q marks that the previous M-cycle closed an instruction
      if (first_q)               count_d = '0;
      else if (count_q == C_MAX) err_d   = 1'b1;
      else                       count_d = count_q + 1'b1;
    end else if (state_q == S_ACTIVE) begin
      if (t_q == T_LAST) begin
        state_d = S_IDLE;
        t_d     = '0;
      end else if (!stall) begin
        t_d = t_q + 1'b1;
      end
    end

    if ((state_q == S_ACTIVE) && (op_q == OP_READ) && (t_q == T_CAP) && !stall)
      rd_data_d = bus.rdata_in;

    // Strobes and pulses are decoded from the next state so they come straight off flops.
    act_d       = (state_d == S_ACTIVE);
    req_rd_d    = act_d && (op_d == OP_READ)  && (t_d != '0) && (t_d != T_LAST);
    req_wr_d    = act_d && (op_d == OP_WRITE) && (t_d != '0) && (t_d != T_LAST);
    rd_valid_d  = act_d && (op_d == OP_READ)  && (t_d == T_LAST);
    insn_done_d = act_d && last_d && (t_d == T_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_INTERNAL;
      t_q         <= '0;
      last_q      <= 1'b0;
      first_q     <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      insn_done_q <= 1'b0;
      req_rd_q    <= 1'b0;
      req_wr_q    <= 1'b0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      t_q         <= t_d;
      last_q      <= last_d;
      first_q     <= first_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      insn_done_q <= insn_done_d;
      req_rd_q    <= req_rd_d;
      req_wr_q    <= req_wr_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign bus.addr_bus      = addr_q;
  assign bus.wdata_out     = wdata_q;
  assign bus.MMU_req_read  = req_rd_q;
  assign bus.MMU_req_write = req_wr_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.insn_done     = insn_done_q;
  assign bus.mcycle_count  = count_q;
  assign bus.busy          = (state_q == S_ACTIVE);
  assign bus.seq_err       = err_q;
endmodule

// File: tb/tb_mcycle_sequencer.sv
// Scoreboard bench: the driver pushes one expected M-cycle summary per accepted
// descriptor; a monitor pops and compares it when the M-cycle reaches its last phase.
module tb_mcycle_sequencer;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int T      = 4;
  localparam int MAXM   = 6;
  localparam int CW     = $clog2(MAXM + 1);
`ifdef MCYCLE_SEQUENCER_WAIT_STATE_EN
  localparam bit WS = 1'b1;
`else
  localparam bit WS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mcycle_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_MCYCLES(MAXM)) bus_if ();

  mcycle_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_PER_M(T), .MAX_MCYCLES(MAXM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    int          len;
    int          nrd;
    int          nwr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    bit          is_rd;
    logic [7:0]  rdata;
    bit          last;
    int          cnt;
    bit          err;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_wdata = '0;
  // reference model: position of the M-cycle inside its instruction
  int   pos = 0;
  bit   first_m = 1'b1;
  bit   err_m = 1'b0;
  int   run = 0;
  int   last_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wd,
                       input logic [7:0] rd, input bit last, input int w);
    int   wexp;
    bit   acc;
    exp_t e;
    wexp = (WS && (op == 2'd1 || op == 2'd2)) ? w : 0;
    bus_if.cyc_op    = op;
    bus_if.cyc_addr  = addr;
    bus_if.cyc_wdata = wd;
    bus_if.cyc_last  = last;
    bus_if.cyc_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      acc = bus_if.cyc_ready;
    end
    if (!acc) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus_if.cyc_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus_if.cyc_valid = 1'b0;
    pos = first_m ? 0 : pos + 1;
    if (pos >= MAXM) err_m = 1'b1;
    first_m = last;
    e.len   = T + wexp;
    e.nrd   = (op == 2'd1) ? T - 2 + wexp : 0;
    e.nwr   = (op == 2'd2) ? T - 2 + wexp : 0;
    e.addr  = addr;
    e.wdata = wd;
    e.is_rd = (op == 2'd1);
    e.rdata = rd;
    e.last  = last;
    e.cnt   = (pos > MAXM - 1) ? MAXM - 1 : pos;
    e.err   = err_m;
    q.push_back(e);
    last_addr  = addr;
    last_wdata = wd;
    // mem_ready low from t=0 through w cycles of the capture phase
    for (int c = 0; c <= T - 2 + wexp; c++) begin
      bus_if.mem_ready = (c >= T - 2 + w);
      bus_if.rdata_in  = rd;
      @(posedge clk);
      #1;
    end
    bus_if.mem_ready = 1'b1;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      idle = !bus_if.busy && (q.size() == 0);
    end
    if (!idle) check("idle_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  int m_len = 0, m_rd = 0, m_wr = 0, m_rv = 0, m_id = 0;
  logic [7:0] m_rdd = '0;
  exp_t me;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_if.busy) begin
        run++;
        m_len++;
        m_rd += int'(bus_if.MMU_req_read);
        m_wr += int'(bus_if.MMU_req_write);
        if (bus_if.MMU_req_read && bus_if.MMU_req_write) check("strobe_excl", 64'd1, 64'd0);
        if (bus_if.rd_valid) begin m_rv++; m_rdd = bus_if.rd_data; end
        if (bus_if.insn_done) m_id++;
        if (bus_if.cyc_ready) begin
          if (q.size() == 0) check("unexpected_mcycle", 64'd1, 64'd0);
          else begin
            me = q.pop_front();
            check("mcycle_len", m_len, me.len);
            check("read_strobes", m_rd, me.nrd);
            check("write_strobes", m_wr, me.nwr);
            check("addr_bus", bus_if.addr_bus, me.addr);
            check("wdata_out", bus_if.wdata_out, me.wdata);
            check("rd_valid_pulses", m_rv, me.is_rd ? 1 : 0);
            if (me.is_rd) check("rd_data", m_rdd, me.rdata);
            check("insn_done_pulses", m_id, me.last ? 1 : 0);
            check("mcycle_count", bus_if.mcycle_count, me.cnt);
            check("seq_err", bus_if.seq_err, me.err);
          end
          m_len = 0; m_rd = 0; m_wr = 0; m_rv = 0; m_id = 0;
        end
      end else begin
        if (run > 0) last_run = run;
        run = 0;
        check("idle_outputs", {bus_if.MMU_req_read, bus_if.MMU_req_write,
                               bus_if.rd_valid, bus_if.insn_done}, 64'd0);
        check("idle_addr_hold", bus_if.addr_bus, last_addr);
        check("idle_wdata_hold", bus_if.wdata_out, last_wdata);
      end
    end
  end

  initial begin
    bus_if.cyc_valid = 1'b0;
    bus_if.cyc_op    = 2'd0;
    bus_if.cyc_addr  = '0;
    bus_if.cyc_wdata = '0;
    bus_if.cyc_last  = 1'b0;
    bus_if.rdata_in  = '0;
    bus_if.mem_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", bus_if.busy, 64'd0);
    check("rst_cyc_ready", bus_if.cyc_ready, 64'd1);
    check("rst_addr_bus", bus_if.addr_bus, 64'd0);
    check("rst_wdata_out", bus_if.wdata_out, 64'd0);
    check("rst_rd_data", bus_if.rd_data, 64'd0);
    check("rst_strobes", {bus_if.MMU_req_read, bus_if.MMU_req_write,
                          bus_if.rd_valid, bus_if.insn_done}, 64'd0);
    check("rst_mcycle_count", bus_if.mcycle_count, 64'd0);
    check("rst_seq_err", bus_if.seq_err, 64'd0);
    @(posedge clk);
    #1 mon_en = 1'b1;

    issue(2'd1, 16'h0150, 8'h00, 8'h3E, 1'b1, 0);
    wait_idle();

    issue(2'd1, 16'h1234, 8'h00, 8'hA7, 1'b0, 0);
    issue(2'd3, 16'h0000, 8'h00, 8'h00, 1'b0, 0);
    issue(2'd2, 16'hC000, 8'h5A, 8'h00, 1'b1, 0);
    wait_idle();
    check("b2b_busy_run", last_run, 12);

    issue(2'd2, 16'h8000, 8'h11, 8'h00, 1'b1, 3);
    wait_idle();
    check("wait_state_len", last_run, WS ? 7 : 4);

    for (int n = 0; n < 40; n++) begin
      int g;
      issue(2'($urandom_range(3)), 16'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(2) == 0), int'($urandom_range(3)));
      g = $urandom_range(2);
      repeat (g) begin @(posedge clk); #1; end
    end
    issue(2'd3, 16'h0001, 8'h01, 8'h00, 1'b1, 0);
    wait_idle();

    for (int n = 0; n < 7; n++) issue(2'd3, 16'($urandom), 8'($urandom), 8'h00, 1'b0, 0);
    wait_idle();
    check("overrun_seq_err", bus_if.seq_err, 64'd1);
    check("overrun_count_sat", bus_if.mcycle_count, 64'(MAXM - 1));

    // abort a WRITE at t=2 with reset
    mon_en = 1'b0;
    bus_if.cyc_op = 2'd2; bus_if.cyc_addr = 16'hBEEF; bus_if.cyc_wdata = 8'h77;
    bus_if.cyc_last = 1'b1; bus_if.cyc_valid = 1'b1;
    @(negedge clk);
    check("abort_accept_ready", bus_if.cyc_ready, 64'd1);
    @(posedge clk); #1 bus_if.cyc_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_write_active", bus_if.MMU_req_write, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_write_off", bus_if.MMU_req_write, 64'd0);
    check("abort_busy_off", bus_if.busy, 64'd0);
    check("abort_seq_err_clr", bus_if.seq_err, 64'd0);
    check("abort_addr_clr", bus_if.addr_bus, 64'd0);
    for (int i = 0; i < T; i++) begin
      check("abort_no_pulse", {bus_if.insn_done, bus_if.rd_valid}, 64'd0);
      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mcycle_sequencer.md
MCYCLE_SEQUENCER -- requirements
Module: mcycle_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, address bus width.
REQ-002 The block SHALL have parameter DATA_W, default 8, data bus width.
REQ-003 The block SHALL have parameter T_PER_M, default 4, T-phases per M-cycle; legal range 3..8.
REQ-004 The block SHALL have parameter MAX_MCYCLES, default 6, maximum M-cycles per instruction; CW = $clog2(MAX_MCYCLES+1).
REQ-005 The block SHALL have these ports, one per line below:
  clk  in  1  clock; all logic on posedge
  reset  in  1  synchronous active-high reset
  cyc_valid  in  1  micro-cycle descriptor offered
  cyc_ready  out  1  descriptor accepted when cyc_valid && cyc_ready
  cyc_op  in  2  0 IDLE, 1 READ, 2 WRITE, 3 INTERNAL
  cyc_addr  in  ADDR_W  address for READ/WRITE
  cyc_wdata  in  DATA_W  write data
  cyc_last  in  1  final M-cycle of the instruction
  addr_bus  out  ADDR_W  memory address
  wdata_out  out  DATA_W  write data to MMU
  rdata_in  in  DATA_W  read data from MMU
  MMU_req_read  out  1  read strobe
  MMU_req_write  out  1  write strobe
  mem_ready  in  1  MMU completion (wait-state control)
  rd_data  out  DATA_W  captured read byte
  rd_valid  out  1  one-cycle pulse, rd_data valid
  insn_done  out  1  one-cycle pulse at instruction end
  mcycle_count  out  CW  M-cycle index within current instruction
  busy  out  1  M-cycle in progress
  seq_err  out  1  sticky overrun flag

Function
REQ-006 State SHALL be IDLE or ACTIVE with phase counter t in 0..T_PER_M-1; busy = ACTIVE.
REQ-007 cyc_ready SHALL be 1 in IDLE and in phase t=T_PER_M-1 (unless stalled per REQ-012), else 0.
REQ-008 On acceptance the descriptor SHALL be latched and t=0 SHALL begin the next cycle; cyc_op IDLE accepted SHALL be treated as INTERNAL.
REQ-009 addr_bus and wdata_out SHALL present the latched values from t=0 until the next acceptance; they hold their last value in IDLE.
REQ-010 For READ, MMU_req_read SHALL be 1 in phases t=1..T_PER_M-2; for WRITE, MMU_req_write likewise; INTERNAL asserts neither; both never 1 simultaneously.
REQ-011 READ SHALL capture rdata_in into rd_data on the edge ending t=T_PER_M-2 (when not stalled); rd_valid SHALL pulse during t=T_PER_M-1.
REQ-012 Stall: see REQ-021; during a stall t, strobes and addr_bus SHALL hold.
REQ-013 Acceptance at t=T_PER_M-1 SHALL start the next M-cycle at t=0 with no bubble; no acceptance returns to IDLE.
REQ-014 insn_done SHALL pulse during t=T_PER_M-1 of an M-cycle latched with cyc_last=1; mcycle_count SHALL then return to 0 at the next M-cycle, else increment.
REQ-015 If mcycle_count would exceed MAX_MCYCLES-1 without cyc_last, seq_err SHALL set and mcycle_count SHALL saturate; sequencing continues.

Reset
REQ-016 On reset: IDLE, t=0, addr_bus=0, wdata_out=0, rd_data=0, all strobes/pulses 0, mcycle_count=0, seq_err=0, cyc_ready 1 the following cycle.
REQ-017 Reset mid-M-cycle SHALL abort it: strobes 0 the cycle after the reset edge; no rd_valid or insn_done for the aborted cycle.
REQ-018 seq_err SHALL clear only by reset.

Configuration
REQ-019 Macro MCYCLE_SEQUENCER_WAIT_STATE_EN SHALL compile wait-state support in or out.
REQ-020 Without it, mem_ready SHALL be ignored; every M-cycle is exactly T_PER_M cycles.
REQ-021 With it, READ/WRITE with mem_ready=0 at t=T_PER_M-2 SHALL stall in that phase until mem_ready=1; INTERNAL ignores mem_ready.

Verification
REQ-022 Reset pulse -> REQ-016 values; busy=0, cyc_ready=1.
REQ-023 READ 0x0150, rdata_in=0x3E, mem_ready=1 -> MMU_req_read 2 cycles, rd_valid with rd_data=0x3E 4 cycles after acceptance.
REQ-024 READ, INTERNAL, WRITE 0xC000/0x5A (last) back-to-back -> 12 busy cycles, no bubble, mcycle_count 0,1,2, one insn_done, wdata_out=0x5A.
REQ-025 With macro: WRITE with mem_ready=0 for 3 cycles -> M-cycle 7 cycles, MMU_req_write 5 cycles; without macro same stimulus -> 4 cycles.
REQ-026 Reset asserted during WRITE at t=2 -> MMU_req_write=0 and busy=0 next cycle, no insn_done.
REQ-027 MAX_MCYCLES=6, 7 descriptors with cyc_last=0 -> seq_err=1 on 7th, mcycle_count holds 5.
